// File: rtl/lcd_pkg.sv
// Shared constants, request struct and timing helpers for the HD44780 4-bit text controller.
package lcd_pkg;

    localparam logic [7:0] CMD_FSET      = 8'h28;
    localparam logic [7:0] CMD_ENTRY     = 8'h06;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] CHAR_NEWLINE  = 8'h0A;

    localparam logic [63:0] T_PWR_NS   = 64'd15_000_000;
    localparam logic [63:0] T_N3A_NS   = 64'd4_100_000;
    localparam logic [63:0] T_N3B_NS   = 64'd100_000;
    localparam logic [63:0] T_SHORT_NS = 64'd40_000;
    localparam logic [63:0] T_LONG_NS  = 64'd1_640_000;
    localparam logic [63:0] T_E_LOW_NS = 64'd1_000;

    typedef enum logic [2:0] {
        S_PWR_WAIT,
        S_INIT_NIB,
        S_INIT_GAP,
        S_INIT_CMD,
        S_IDLE,
        S_DATA,
        S_CMD
    } ctrl_state_t;

    typedef enum logic [2:0] {
        W_IDLE,
        W_SETUP,
        W_PULSE,
        W_GAP,
        W_WAIT
    } wr_state_t;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
        logic       long_wait;
        logic       nibble_only;
    } wr_req_t;

    // ceil(t * clk_hz), never below one cycle so counters can always load (n - 1)
    function automatic logic [31:0] delay_cyc(logic [63:0] t_ns, logic [63:0] clk_hz);
        logic [63:0] c;
        c = (t_ns * clk_hz + 64'd999_999_999) / 64'd1_000_000_000;
        if (c == 64'd0) c = 64'd1;
        return c[31:0];
    endfunction

    function automatic logic [6:0] row_base(logic [1:0] row);
        case (row)
            2'd0:    return 7'h00;
            2'd1:    return 7'h40;
            2'd2:    return 7'h14;
            default: return 7'h54;
        endcase
    endfunction

    function automatic logic [7:0] init_cmd(logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_FSET;
            2'd1:    return CMD_ENTRY;
            2'd2:    return CMD_DISP_ON;
            default: return CMD_CLEAR;
        endcase
    endfunction

    function automatic wr_req_t cmd_req(logic [7:0] b);
        wr_req_t r;
        r.rs          = 1'b0;
        r.data        = b;
        r.long_wait   = (b == CMD_CLEAR) || (b == CMD_HOME);
        r.nibble_only = 1'b0;
        return r;
    endfunction

    function automatic wr_req_t data_req(logic [7:0] b);
        wr_req_t r;
        r.rs          = 1'b1;
        r.data        = b;
        r.long_wait   = 1'b0;
        r.nibble_only = 1'b0;
        return r;
    endfunction

    function automatic wr_req_t nib_req(logic [3:0] n);
        wr_req_t r;
        r.rs          = 1'b0;
        r.data        = {4'h0, n};
        r.long_wait   = 1'b0;
        r.nibble_only = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Drives one byte (two nibbles) or a single init nibble onto the 4-bit LCD bus,
// including setup, E pulse, E-low gap and the post-write execution delay.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned E_PULSE_CYC = 12
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iStart,
    input  logic       iRS,
    input  logic [7:0] iByte,
    input  logic       iLongWait,
    input  logic       iNibbleOnly,
    output logic       oDone,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic [3:0] oLCD_Data
);

    localparam logic [31:0] SETUP_CYC = 32'd2;
    localparam logic [31:0] PULSE_CYC = 32'(E_PULSE_CYC);
    localparam logic [31:0] GAP_CYC   = delay_cyc(T_E_LOW_NS, 64'(CLK_HZ));
    localparam logic [31:0] SHORT_CYC = delay_cyc(T_SHORT_NS, 64'(CLK_HZ));
    localparam logic [31:0] LONG_CYC  = delay_cyc(T_LONG_NS, 64'(CLK_HZ));

    wr_state_t   state;
    logic [31:0] cnt;
    logic [3:0]  low_nib;
    logic        second;
    logic        nib_only;
    logic        long_wait;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state               <= W_IDLE;
            cnt                 <= '0;
            low_nib             <= '0;
            second              <= 1'b0;
            nib_only            <= 1'b0;
            long_wait           <= 1'b0;
            oDone               <= 1'b0;
            oLCD_Enabled        <= 1'b0;
            oLCD_RegisterSelect <= 1'b0;
            oLCD_Data           <= '0;
        end else begin
            oDone <= 1'b0;
            case (state)
                W_IDLE: begin
                    if (iStart) begin
                        oLCD_RegisterSelect <= iRS;
                        oLCD_Data           <= iNibbleOnly ? iByte[3:0] : iByte[7:4];
                        low_nib             <= iByte[3:0];
                        nib_only            <= iNibbleOnly;
                        long_wait           <= iLongWait;
                        second              <= 1'b0;
                        cnt                 <= SETUP_CYC - 32'd1;
                        state               <= W_SETUP;
                    end
                end
                W_SETUP: begin
                    if (cnt == '0) begin
                        oLCD_Enabled <= 1'b1;
                        cnt          <= PULSE_CYC - 32'd1;
                        state        <= W_PULSE;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                W_PULSE: begin
                    if (cnt == '0) begin
                        oLCD_Enabled <= 1'b0;
                        // the low nibble goes straight into the execution delay
                        if (second) begin
                            cnt   <= (long_wait ? LONG_CYC : SHORT_CYC) - 32'd1;
                            state <= W_WAIT;
                        end else begin
                            cnt   <= GAP_CYC - 32'd1;
                            state <= W_GAP;
                        end
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                W_GAP: begin
                    if (cnt == '0) begin
                        if (nib_only) begin
                            oDone <= 1'b1;
                            state <= W_IDLE;
                        end else begin
                            oLCD_Data <= low_nib;
                            second    <= 1'b1;
                            cnt       <= SETUP_CYC - 32'd1;
                            state     <= W_SETUP;
                        end
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                W_WAIT: begin
                    if (cnt == '0) begin
                        oDone <= 1'b1;
                        state <= W_IDLE;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                default: state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_text_ctrl.sv
// Character-stream front end for an HD44780 in 4-bit mode: power-on init, FIFO,
// cursor tracking with line wrap, newline and latched clear.
module lcd_text_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned COLS        = 16,
    parameter int unsigned ROWS        = 2,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned E_PULSE_CYC = 12
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iCharValid,
    input  logic [7:0] iChar,
    output logic       oCharReady,
    input  logic       iClear,
    output logic       oInitDone,
    output logic       oBusy,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic       oLCD_ReadWrite,
    output logic       oLCD_StrataFlashControl,
    output logic [3:0] oLCD_Data
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [31:0] PWR_CYC   = delay_cyc(T_PWR_NS, 64'(CLK_HZ));
    localparam logic [31:0] N3A_CYC   = delay_cyc(T_N3A_NS, 64'(CLK_HZ));
    localparam logic [31:0] N3B_CYC   = delay_cyc(T_N3B_NS, 64'(CLK_HZ));
    localparam logic [31:0] SHORT_CYC = delay_cyc(T_SHORT_NS, 64'(CLK_HZ));
    // start, writer pickup and 2-cycle setup are absorbed so E first rises PWR_CYC edges after release
    localparam logic [31:0] PWR_LOAD  = (PWR_CYC > 32'd4) ? PWR_CYC - 32'd4 : 32'd0;

    // Character FIFO
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic [7:0]  head;

    ctrl_state_t state;
    logic [31:0] cnt;
    logic [1:0]  step;
    logic [1:0]  row;
    logic [5:0]  col;
    logic        clear_latch;
    logic        start;
    wr_req_t     req;
    logic        done;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign oCharReady = oInitDone && !full;
    assign push       = iCharValid && oCharReady;
    assign pop        = (state == S_IDLE) && !clear_latch && !empty;
    assign head       = mem[rd_ptr[AW-1:0]];

    assign oBusy                   = !((state == S_IDLE) && empty && !clear_latch);
    assign oLCD_ReadWrite          = 1'b0;
    assign oLCD_StrataFlashControl = 1'b1;

    function automatic logic [1:0] next_row(logic [1:0] r);
        return (r == 2'(ROWS - 1)) ? 2'd0 : r + 2'd1;
    endfunction

    function automatic logic [31:0] nib_wait(logic [1:0] idx);
        case (idx)
            2'd0:    return N3A_CYC;
            2'd1:    return N3B_CYC;
            default: return SHORT_CYC;
        endcase
    endfunction

    always_ff @(posedge Clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= iChar;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state       <= S_PWR_WAIT;
            cnt         <= PWR_LOAD;
            step        <= '0;
            row         <= '0;
            col         <= '0;
            clear_latch <= 1'b0;
            start       <= 1'b0;
            req         <= '0;
            oInitDone   <= 1'b0;
        end else begin
            start <= 1'b0;
            if (iClear) clear_latch <= 1'b1;
            case (state)
                S_PWR_WAIT: begin
                    if (cnt == '0) begin
                        req   <= nib_req(4'h3);
                        start <= 1'b1;
                        step  <= '0;
                        state <= S_INIT_NIB;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                S_INIT_NIB: begin
                    if (done) begin
                        cnt   <= nib_wait(step) - 32'd1;
                        state <= S_INIT_GAP;
                    end
                end
                S_INIT_GAP: begin
                    if (cnt == '0) begin
                        start <= 1'b1;
                        if (step == 2'd3) begin
                            step  <= '0;
                            req   <= cmd_req(init_cmd(2'd0));
                            state <= S_INIT_CMD;
                        end else begin
                            step  <= step + 2'd1;
                            req   <= nib_req((step == 2'd2) ? 4'h2 : 4'h3);
                            state <= S_INIT_NIB;
                        end
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                S_INIT_CMD: begin
                    if (done) begin
                        if (step == 2'd3) begin
                            oInitDone <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            step  <= step + 2'd1;
                            req   <= cmd_req(init_cmd(step + 2'd1));
                            start <= 1'b1;
                        end
                    end
                end
                S_IDLE: begin
                    if (clear_latch) begin
                        // a clear arriving in this very cycle stays latched for the next pass
                        clear_latch <= iClear;
                        row         <= '0;
                        col         <= '0;
                        req         <= cmd_req(CMD_CLEAR);
                        start       <= 1'b1;
                        state       <= S_CMD;
                    end else if (!empty) begin
                        start <= 1'b1;
                        if (head == CHAR_NEWLINE) begin
                            row   <= next_row(row);
                            col   <= '0;
                            req   <= cmd_req(CMD_SET_DDRAM | {1'b0, row_base(next_row(row))});
                            state <= S_CMD;
                        end else begin
                            req   <= data_req(head);
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (done) begin
                        if (col == 6'(COLS - 1)) begin
                            col   <= '0;
                            row   <= next_row(row);
                            req   <= cmd_req(CMD_SET_DDRAM | {1'b0, row_base(next_row(row))});
                            start <= 1'b1;
                            state <= S_CMD;
                        end else begin
                            col   <= col + 6'd1;
                            state <= S_IDLE;
                        end
                    end
                end
                S_CMD: begin
                    if (done) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    lcd_byte_writer #(
        .CLK_HZ      (CLK_HZ),
        .E_PULSE_CYC (E_PULSE_CYC)
    ) u_writer (
        .Clock               (Clock),
        .Reset               (Reset),
        .iStart              (start),
        .iRS                 (req.rs),
        .iByte               (req.data),
        .iLongWait           (req.long_wait),
        .iNibbleOnly         (req.nibble_only),
        .oDone               (done),
        .oLCD_Enabled        (oLCD_Enabled),
        .oLCD_RegisterSelect (oLCD_RegisterSelect),
        .oLCD_Data           (oLCD_Data)
    );

endmodule

// File: doc/lcd_text_ctrl.md
Name: lcd_text_ctrl

Overview:
- Parametrised successor of the team's single-character HD44780 4-bit LCD driver (Spartan-3E board LCD).
- Accepts a stream of ASCII bytes through a valid/ready FIFO and performs the full power-on init.
- Tracks the cursor across ROWS x COLS, wraps lines, handles newline and an asynchronous clear request.
- Sits between the ALU/result formatter and the LCD pins.

Parameters:
- CLK_HZ, 50000000, clock frequency; every LCD delay is derived from it as ceil(t*CLK_HZ).
- COLS, 16, visible columns per row (1..40).
- ROWS, 2, display rows (1, 2 or 4).
- FIFO_DEPTH, 16, character FIFO entries (power of two, >=2).
- E_PULSE_CYC, 12, cycles oLCD_Enabled is held high per nibble (>=12 at 50 MHz, i.e. >=230 ns).

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- iCharValid  in  1  character byte offered.
- iChar  in  8  ASCII code; 8'h0A = newline.
- oCharReady  out  1  FIFO not full; transfer occurs when iCharValid && oCharReady.
- iClear  in  1  single-cycle clear request, latched.
- oInitDone  out  1  power-on sequence complete.
- oBusy  out  1  LCD bus activity, FIFO non-empty, or clear pending.
- oLCD_Enabled  out  1  LCD E.
- oLCD_RegisterSelect  out  1  0 = command, 1 = data.
- oLCD_ReadWrite  out  1  constant 0.
- oLCD_StrataFlashControl  out  1  constant 1.
- oLCD_Data  out  4  LCD DB7..DB4.

Behaviour:
- Reset (Reset=0, asynchronous) values: oLCD_Enabled=0, oLCD_RegisterSelect=0, oLCD_Data=0, oInitDone=0, oBusy=1, oCharReady=0.
  - FIFO emptied, cursor set to (0,0), clear latch cleared.
  - Reset asserted mid-operation aborts any transfer; release restarts from PWR_WAIT.
- Init FSM states and actions:
  - PWR_WAIT: 15 ms.
  - N3a: E pulse, data 0x3. Then wait 4.1 ms.
  - N3b: E pulse, data 0x3. Then wait 100 us.
  - N3c: E pulse, data 0x3. Then wait 40 us.
  - N2: E pulse, data 0x2. Then wait 40 us.
  - Byte commands: 0x28, 0x06, 0x0C, 0x01, then wait 1.64 ms.
  - Enter IDLE with oInitDone=1; oCharReady follows FIFO-not-full from then on.
- Byte write (shared by all commands and data), sequence:
  - Setup: drive the high nibble with RS stable for 2 cycles.
  - Pulse: E high E_PULSE_CYC cycles, then E low for 1 us.
  - Low nibble: same setup and E pulse.
  - Wait 40 us, or 1.64 ms if the command is 0x01/0x02.
  - oLCD_Data holds its value while E is high.
  - RS must not change between the setup cycle and E falling.
- IDLE priority each cycle:
  1. Clear latch: send 0x01; cursor=(0,0); latch cleared. FIFO contents kept.
  2. FIFO non-empty: pop one byte.
  3. Otherwise stay in IDLE.
- Popped-byte handling:
  - 8'h0A: row=(row+1) mod ROWS, col=0, then send Set-DDRAM command 0x80|addr.
  - Any other byte: data write, then col++.
  - If col reaches COLS: col=0, row advances (last row wraps to row 0), then Set-DDRAM for the new position.
- Row base addresses: row0 0x00, row1 0x40, row2 0x14, row3 0x54. addr = base+col.
- FIFO behaviour:
  - Push and pop in the same cycle are allowed; occupancy unchanged.
  - Push while full is ignored (oCharReady=0 guarantees this).
  - Pop never happens while empty.
  - Pointers are log2(FIFO_DEPTH)+1 bits with natural wrap.
- iClear arriving during init or during a byte write is latched and served at the next IDLE.
- Characters arriving during init are buffered only once oInitDone=1; before that oCharReady=0.
- oBusy=0 only in IDLE with FIFO empty and no clear latched.

Decomposition:
- Shared package lcd_pkg holds:
  - Command constants: FSET 0x28, ENTRY 0x06, DISP_ON 0x0C, CLEAR 0x01, SET_DDRAM 0x80.
  - Row-base table.
  - The delay-in-cycles function of CLK_HZ.
  - FSM state encodings.
- Sub-module lcd_byte_writer: iStart/iRS/iByte/iLongWait in, oDone plus pin outputs; implements the nibble/E/delay sequence.
  - The init nibbles reuse its E-pulse path through a nibble-only mode input.

Test Plan:
- Power-on (CLK_HZ=1000000, so 15 ms = 15000 cycles):
  - E rises first at cycle 15000±2 with oLCD_Data=0x3.
  - Nibble order observed: 3,3,3,2,2,8,0,6,0,C,0,1.
  - oInitDone rises after the last wait.
- Push "AB" after init -> RS=1 nibbles 4,1,4,2. Cursor (0,2).
- With COLS=16, ROWS=2, push 17 characters 'a'..'q':
  - After the 16th character, command nibbles 0xC0 (row1 col0) are sent, then 'q'.
  - A further 16 characters wrap back to 0x80.
- Push 'X', 0x0A, 'Y' -> data 0x58, command 0xC0, data 0x59.
- Hold iCharValid=1 with FIFO_DEPTH=4 while the LCD is busy:
  - oCharReady drops after 4 accepted bytes.
  - No byte is lost or duplicated on the bus.
- Pulse iClear during a data write:
  - The write completes, then 0x01 is sent, then a 1.64 ms gap.
  - Queued bytes then follow at address 0x00.
- Assert Reset=0 mid-nibble with E high -> E=0 and oLCD_Data=0 immediately, and the full init replays after release.
